// File: rtl/mem_request_responder_if.sv
// Request-unit <-> memory responder bus, including the RAM-side signals.
// The responder takes the slave view; the request unit / RAM model the master view.
interface mem_request_responder_if;
  // Request unit side
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic [31:0] dmemload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  // Completed-access counters
  logic [31:0] icount;
  logic [31:0] dcount;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload,
    output ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore,
           icount, dcount
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload,
    input  ihit, imemload, dhit, dmemload, ramREN, ramWEN, ramaddr, ramstore,
           icount, dcount
  );
endinterface

// File: rtl/mem_request_responder.sv
// Memory-side responder: arbitrates instruction and data requests onto one
// single-port word RAM, inserting LAT wait cycles between acceptance and hit.
// Data requests win over instruction requests. A write wins over a read when
// both data strobes are high.
// Optional feature macro: MEM_RESP_COUNT_EN builds the icount/dcount
// completed-access counters; without it both counters read as 0.
module mem_request_responder #(
  parameter int LAT = 2  // wait cycles, 0..15
) (
  input logic                     CLK,
  input logic                     nRST,
  mem_request_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, HIT} state_t;
  typedef enum logic       {OWN_I, OWN_D}    owner_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  owner_t      owner_q;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic        wr_q;

  logic        d_req, any_req, owner_req;
  owner_t      acc_owner;
  logic [31:0] acc_addr;
  logic        acc_wr;
  logic        accept;

  logic        hit;
  owner_t      hit_owner;
  logic        hit_wr;
  logic [31:0] hit_addr;
  logic [31:0] hit_store;
  logic        ihit, dhit;

  // Arbitration: data beats instruction; both data strobes mean a write.
  always_comb begin
    d_req     = bus.dmemREN | bus.dmemWEN;
    any_req   = d_req | bus.imemREN;
    acc_owner = d_req ? OWN_D : OWN_I;
    acc_addr  = d_req ? bus.dmemaddr : bus.imemaddr;
    acc_wr    = bus.dmemWEN;
    owner_req = (owner_q == OWN_D) ? d_req : bus.imemREN;
  end

  // Next-state and hit selection. With LAT=0 the hit is produced from IDLE
  // directly off the live inputs, gated by nRST so reset forces outputs low.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    accept    = 1'b0;
    hit       = 1'b0;
    hit_owner = owner_q;
    hit_wr    = wr_q;
    hit_addr  = addr_q;
    hit_store = store_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          accept = 1'b1;
          if (LAT_CNT == 4'd0) begin
            hit       = nRST;
            hit_owner = acc_owner;
            hit_wr    = acc_wr;
            hit_addr  = acc_addr;
            hit_store = bus.dmemstore;
          end else if (LAT_CNT == 4'd1) begin
            state_d = HIT;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Dropping the owner's strobe abandons the access without a RAM strobe.
        if (!owner_req)           state_d = IDLE;
        else if (cnt_q == 4'd2)   state_d = HIT;
      end
      HIT: begin
        hit     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter and request latches. The counter holds 1 in HIT.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the address/data latches are plain flops, not a memory array, so
      // they are reset along with the control state to give clean idle outputs.
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      owner_q <= OWN_D;
      addr_q  <= 32'd0;
      store_q <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (accept) begin
        owner_q <= acc_owner;
        addr_q  <= acc_addr;
        wr_q    <= acc_wr;
        store_q <= bus.dmemstore;
        cnt_q   <= LAT_CNT;
      end else if (state_q == BUSY && state_d == IDLE) begin
        cnt_q <= 4'd0;
      end else if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Output steering: only the owner sees the hit and load data.
  always_comb begin
    ihit         = hit && (hit_owner == OWN_I);
    dhit         = hit && (hit_owner == OWN_D);
    bus.ihit     = ihit;
    bus.dhit     = dhit;
    bus.imemload = ihit ? bus.ramload : 32'd0;
    bus.dmemload = (dhit && !hit_wr) ? bus.ramload : 32'd0;
    bus.ramREN   = hit && !hit_wr;
    bus.ramWEN   = hit && hit_wr;
    bus.ramaddr  = hit ? hit_addr : 32'd0;
    bus.ramstore = (hit && hit_wr) ? hit_store : 32'd0;
  end

`ifdef MEM_RESP_COUNT_EN
  logic [31:0] icount_q, dcount_q;

  // Completed-access counters, wrapping modulo 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= 32'd0;
      dcount_q <= 32'd0;
    end else begin
      if (ihit) icount_q <= icount_q + 32'd1;
      if (dhit) dcount_q <= dcount_q + 32'd1;
    end
  end

  assign bus.icount = icount_q;
  assign bus.dcount = dcount_q;
`else
  assign bus.icount = 32'd0;
  assign bus.dcount = 32'd0;
`endif

endmodule

// File: tb/tb_mem_request_responder.sv
// Bench for mem_request_responder: four instances with LAT = 0..3 share one
// stimulus set; each scenario observes the instance with the latency it needs.
module tb_mem_request_responder;

`ifdef MEM_RESP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        imem_ren, dmem_ren, dmem_wen;
  logic [31:0] imem_addr, dmem_addr, dmem_store, ram_data;

  logic [3:0]  ihit_v, dhit_v, ren_v, wen_v;
  logic [31:0] iload_v [4];
  logic [31:0] dload_v [4];
  logic [31:0] raddr_v [4];
  logic [31:0] rstore_v[4];
  logic [31:0] icnt_v  [4];
  logic [31:0] dcnt_v  [4];

  logic [15:0] im_m[4];
  logic [15:0] dm_m[4];
  logic [15:0] rr_m[4];

  int n_checks = 0;
  int n_err    = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_request_responder_if bus ();
    assign bus.imemREN   = imem_ren;
    assign bus.imemaddr  = imem_addr;
    assign bus.dmemREN   = dmem_ren;
    assign bus.dmemWEN   = dmem_wen;
    assign bus.dmemaddr  = dmem_addr;
    assign bus.dmemstore = dmem_store;
    assign bus.ramload   = ram_data;

    mem_request_responder #(.LAT(g)) u_dut (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (bus.slave)
    );

    assign ihit_v[g]   = bus.ihit;
    assign dhit_v[g]   = bus.dhit;
    assign ren_v[g]    = bus.ramREN;
    assign wen_v[g]    = bus.ramWEN;
    assign iload_v[g]  = bus.imemload;
    assign dload_v[g]  = bus.dmemload;
    assign raddr_v[g]  = bus.ramaddr;
    assign rstore_v[g] = bus.ramstore;
    assign icnt_v[g]   = bus.icount;
    assign dcnt_v[g]   = bus.dcount;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ireq, dren, dwen;
    logic [31:0] iaddr, daddr, dstore, rload;
    logic        e_ihit, e_dhit;
    logic [31:0] e_iload, e_dload;
    logic        e_ren, e_wen;
    logic [31:0] e_raddr, e_rstore;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    imem_ren = 1'b0;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs n cycles from the current one, recording per-cycle hit and RAM-strobe
  // masks for every instance. With drop set, a strobe is released the cycle
  // after instance sel reports its hit, as a request unit would.
  task automatic run_masks(input int n, input int sel, input bit drop);
    logic got_i, got_d;
    for (int k = 0; k < 4; k++) begin
      im_m[k] = '0; dm_m[k] = '0; rr_m[k] = '0;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        im_m[k][c] = ihit_v[k];
        dm_m[k][c] = dhit_v[k];
        rr_m[k][c] = ren_v[k] | wen_v[k];
      end
      got_i = ihit_v[sel];
      got_d = dhit_v[sel];
      @(posedge clk); #1;
      if (drop && got_i) imem_ren = 1'b0;
      if (drop && got_d) begin
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
      end
    end
  endtask

  initial begin
    //           ireq dren dwen iaddr   daddr   dstore        rload         ihit dhit iload         dload         ren wen raddr   rstore
    vecs[0] = '{1'b0,1'b0,1'b0,32'h40, 32'h200,32'hDEADBEEF,32'h2402000A,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'h0,  32'h0};
    vecs[1] = '{1'b1,1'b0,1'b0,32'h40, 32'h200,32'hDEADBEEF,32'h2402000A,1'b1,1'b0,32'h2402000A,32'h0,        1'b1,1'b0,32'h40, 32'h0};
    vecs[2] = '{1'b0,1'b0,1'b1,32'h40, 32'h200,32'hDEADBEEF,32'h12345678,1'b0,1'b1,32'h0,        32'h0,        1'b0,1'b1,32'h200,32'hDEADBEEF};
    vecs[3] = '{1'b0,1'b1,1'b0,32'h44, 32'h104,32'h11111111,32'hCAFEF00D,1'b0,1'b1,32'h0,        32'hCAFEF00D,1'b1,1'b0,32'h104,32'h0};
    vecs[4] = '{1'b1,1'b1,1'b0,32'h48, 32'h108,32'h11111111,32'hA5A5A5A5,1'b0,1'b1,32'h0,        32'hA5A5A5A5,1'b1,1'b0,32'h108,32'h0};
    vecs[5] = '{1'b0,1'b1,1'b1,32'h4C, 32'h10C,32'h0BADF00D,32'h77777777,1'b0,1'b1,32'h0,        32'h0,        1'b0,1'b1,32'h10C,32'h0BADF00D};
    vecs[6] = '{1'b1,1'b1,1'b1,32'h50, 32'h110,32'h5555AAAA,32'h66666666,1'b0,1'b1,32'h0,        32'h0,        1'b0,1'b1,32'h110,32'h5555AAAA};

    rst_n = 1'b0; imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
    imem_addr = 32'h0; dmem_addr = 32'h0; dmem_store = 32'h0; ram_data = 32'h0;

    // Outputs stay low in reset even with requests present (LAT=0 included).
    #2;
    imem_ren = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h200;
    dmem_store = 32'hDEADBEEF; ram_data = 32'h12345678;
    #1;
    check("rst lat0 dhit",     {31'd0, dhit_v[0]}, 32'd0);
    check("rst lat0 ihit",     {31'd0, ihit_v[0]}, 32'd0);
    check("rst lat0 ramWEN",   {31'd0, wen_v[0]},  32'd0);
    check("rst lat0 ramaddr",  raddr_v[0],         32'd0);
    check("rst lat0 ramstore", rstore_v[0],        32'd0);
    check("rst lat2 ramREN",   {31'd0, ren_v[2]},  32'd0);
    check("rst lat2 imemload", iload_v[2],         32'd0);
    check("rst icount",        icnt_v[0],          32'd0);
    check("rst dcount",        dcnt_v[0],          32'd0);
    do_reset();

    // Combinational LAT=0 vectors: every request hits in its own cycle.
    for (int i = 0; i < 7; i++) begin
      imem_ren = vecs[i].ireq;  dmem_ren = vecs[i].dren;  dmem_wen = vecs[i].dwen;
      imem_addr = vecs[i].iaddr; dmem_addr = vecs[i].daddr;
      dmem_store = vecs[i].dstore; ram_data = vecs[i].rload;
      @(negedge clk);
      check($sformatf("vec%0d ihit", i),     {31'd0, ihit_v[0]}, {31'd0, vecs[i].e_ihit});
      check($sformatf("vec%0d dhit", i),     {31'd0, dhit_v[0]}, {31'd0, vecs[i].e_dhit});
      check($sformatf("vec%0d imemload", i), iload_v[0],         vecs[i].e_iload);
      check($sformatf("vec%0d dmemload", i), dload_v[0],         vecs[i].e_dload);
      check($sformatf("vec%0d ramREN", i),   {31'd0, ren_v[0]},  {31'd0, vecs[i].e_ren});
      check($sformatf("vec%0d ramWEN", i),   {31'd0, wen_v[0]},  {31'd0, vecs[i].e_wen});
      check($sformatf("vec%0d ramaddr", i),  raddr_v[0],         vecs[i].e_raddr);
      check($sformatf("vec%0d ramstore", i), rstore_v[0],        vecs[i].e_rstore);
      @(posedge clk); #1;
    end
    imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
    @(negedge clk);
    check("vec icount", icnt_v[0], CNT_EN ? 32'd1 : 32'd0);
    check("vec dcount", dcnt_v[0], CNT_EN ? 32'd5 : 32'd0);

    // LAT=2 instruction fetch: hit in cycle 2 only.
    do_reset();
    imem_ren = 1'b1; imem_addr = 32'h40; ram_data = 32'h2402000A;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("lat2 c%0d ihit", c),     {31'd0, ihit_v[2]}, (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("lat2 c%0d imemload", c), iload_v[2],         (c == 2) ? 32'h2402000A : 32'd0);
      check($sformatf("lat2 c%0d ramREN", c),   {31'd0, ren_v[2]},  (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("lat2 c%0d ramaddr", c),  raddr_v[2],         (c == 2) ? 32'h40 : 32'd0);
      check($sformatf("lat2 c%0d dhit", c),     {31'd0, dhit_v[2]}, 32'd0);
      @(posedge clk); #1;
      if (c == 2) imem_ren = 1'b0;
    end

    // LAT=1 simultaneous I and D: D in cycle 1, I in cycle 3.
    do_reset();
    imem_ren = 1'b1; imem_addr = 32'h44; dmem_ren = 1'b1; dmem_addr = 32'h100;
    ram_data = 32'h0F0F0F0F;
    run_masks(6, 1, 1'b1);
    check("arb dhit cycles", {16'd0, dm_m[1]}, 32'h0002);
    check("arb ihit cycles", {16'd0, im_m[1]}, 32'h0008);
    check("arb no overlap",  {16'd0, im_m[1] & dm_m[1]}, 32'd0);

    // LAT=3 abort: strobe dropped in BUSY, then a fresh request hits 3 later.
    do_reset();
    dmem_ren = 1'b1; dmem_addr = 32'h300; ram_data = 32'h13572468;
    run_masks(1, 3, 1'b0);
    check("abort c0 dhit", {16'd0, dm_m[3]}, 32'd0);
    dmem_ren = 1'b0;
    run_masks(5, 3, 1'b0);
    check("abort no dhit",  {16'd0, dm_m[3]}, 32'd0);
    check("abort no strobe", {16'd0, rr_m[3]}, 32'd0);
    dmem_ren = 1'b1; dmem_addr = 32'h304;
    run_masks(6, 3, 1'b1);
    check("rereq dhit cycles", {16'd0, dm_m[3]}, 32'h0008);

    // Asynchronous reset during LAT=2 HIT and LAT=3 BUSY: drop at once, no stale hit.
    do_reset();
    imem_ren = 1'b1; imem_addr = 32'h80; ram_data = 32'h89ABCDEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst pre ihit", {31'd0, ihit_v[2]}, 32'd1);
    #1;
    rst_n = 1'b0; imem_ren = 1'b0;
    #1;
    check("midrst ihit",     {31'd0, ihit_v[2]}, 32'd0);
    check("midrst ramREN",   {31'd0, ren_v[2]},  32'd0);
    check("midrst ramaddr",  raddr_v[2],         32'd0);
    check("midrst imemload", iload_v[2],         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_masks(6, 2, 1'b0);
    check("midrst lat2 stale", {16'd0, im_m[2] | rr_m[2]}, 32'd0);
    check("midrst lat3 stale", {16'd0, im_m[3] | rr_m[3]}, 32'd0);

    // Held instruction request: back-to-back completions every LAT+1 cycles.
    do_reset();
    imem_ren = 1'b1; imem_addr = 32'h20; ram_data = 32'h00112233;
    run_masks(15, 0, 1'b0);
    check("b2b lat0 ihit", {16'd0, im_m[0]}, 32'h7FFF);
    check("b2b lat1 ihit", {16'd0, im_m[1]}, 32'h2AAA);
    check("b2b lat2 ihit", {16'd0, im_m[2]}, 32'h4924);
    check("b2b lat3 ihit", {16'd0, im_m[3]}, 32'h0888);
    check("b2b lat2 dhit", {16'd0, dm_m[2]}, 32'd0);
    imem_ren = 1'b0;
    @(negedge clk);
    check("b2b lat2 icount", icnt_v[2], CNT_EN ? 32'd5 : 32'd0);
    check("b2b lat2 dcount", dcnt_v[2], 32'd0);
    check("b2b lat0 icount", icnt_v[0], CNT_EN ? 32'd15 : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
